// File: rtl/map_probe_sequencer.sv
// Shares one registered walkability ROM across the eight sprite-corner probes of a
// collision check, then reports map, screen-edge and player/enemy overlap flags.
module map_probe_sequencer #(
  parameter int unsigned SPRITE_SIZE = 16,
  parameter int unsigned MAP_W_PX    = 256,
  parameter int unsigned MAP_H_PX    = 176,
  parameter int unsigned LINE_W      = 320
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  char_x,
  input  logic [7:0]  char_y,
  input  logic [8:0]  enemy1_x,
  input  logic [7:0]  enemy1_y,
  input  logic [2:0]  direction_char,
  input  logic [2:0]  direction_enemy1,
  output logic [16:0] rom_address,
  input  logic        rom_q,
  output logic        busy,
  output logic        done,
  output logic        c_map_collision,
  output logic        e1_map_collision,
  output logic        c_e1_collision
);

  localparam logic [2:0] DIR_UP    = 3'b010;
  localparam logic [2:0] DIR_DOWN  = 3'b011;
  localparam logic [2:0] DIR_LEFT  = 3'b100;
  localparam logic [2:0] DIR_RIGHT = 3'b101;

  typedef enum logic [1:0] {IDLE, PROBE, DRAIN, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [8:0]  cx_q, cx_d, ex_q, ex_d;
  logic [7:0]  cy_q, cy_d, ey_q, ey_d;
  logic [2:0]  cd_q, cd_d, ed_q, ed_d;
  logic        exc_c_q, exc_c_d, exc_e_q, exc_e_d, ovl_q, ovl_d;
  logic        c_ok_q, c_ok_d, e_ok_q, e_ok_d;
  logic [16:0] addr_q;
  logic        c_map_q, c_map_d, e_map_q, e_map_d, c_e1_q, c_e1_d;
  logic [16:0] probe_addr;

  // corner[0] selects the right column, corner[1] the bottom row
  function automatic logic [16:0] corner_addr(input logic [8:0] x, input logic [7:0] y,
                                              input logic [2:0] dir, input logic [1:0] corner);
    logic [8:0] px;
    logic [7:0] py;
    px = x;
    py = y;
    case (dir)
      DIR_UP:    py = y - 8'd1;
      DIR_DOWN:  py = y + 8'd1;
      DIR_LEFT:  px = x - 9'd1;
      DIR_RIGHT: px = x + 9'd1;
      default:   ;
    endcase
    if (corner[0]) px = px + 9'(SPRITE_SIZE);
    if (corner[1]) py = py + 8'(SPRITE_SIZE);
    return 17'(32'(py) * LINE_W + 32'(px));
  endfunction

  function automatic logic edge_exc(input logic [8:0] x, input logic [7:0] y, input logic [2:0] dir);
    logic [9:0] x_end;
    logic [8:0] y_end;
    x_end = {1'b0, x} + 10'(SPRITE_SIZE);
    y_end = {1'b0, y} + 9'(SPRITE_SIZE);
    return ((y == '0) && (dir == DIR_UP))   || ((x == '0) && (dir == DIR_LEFT)) ||
           ((x_end == 10'(MAP_W_PX)) && (dir == DIR_RIGHT)) ||
           ((y_end == 9'(MAP_H_PX)) && (dir == DIR_DOWN));
  endfunction

  function automatic logic near(input logic [8:0] a, input logic [8:0] b);
    logic [8:0] d;
    d = (a >= b) ? a - b : b - a;
    return d < 9'(SPRITE_SIZE);
  endfunction

  always_comb begin
    probe_addr = k_q[2] ? corner_addr(ex_q, ey_q, ed_q, k_q[1:0])
                        : corner_addr(cx_q, cy_q, cd_q, k_q[1:0]);
  end

  assign rom_address      = (state_q == PROBE) ? probe_addr : addr_q;
  assign busy             = (state_q == PROBE) || (state_q == DRAIN);
  assign done             = (state_q == DONE);
  assign c_map_collision  = c_map_q;
  assign e1_map_collision = e_map_q;
  assign c_e1_collision   = c_e1_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    cd_d    = cd_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    ed_d    = ed_q;
    exc_c_d = exc_c_q;
    exc_e_d = exc_e_q;
    ovl_d   = ovl_q;
    c_ok_d  = c_ok_q;
    e_ok_d  = e_ok_q;
    c_map_d = c_map_q;
    e_map_d = e_map_q;
    c_e1_d  = c_e1_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          cx_d    = char_x;
          cy_d    = char_y;
          cd_d    = direction_char;
          ex_d    = enemy1_x;
          ey_d    = enemy1_y;
          ed_d    = direction_enemy1;
          exc_c_d = edge_exc(char_x, char_y, direction_char);
          exc_e_d = edge_exc(enemy1_x, enemy1_y, direction_enemy1);
          ovl_d   = near(char_x, enemy1_x) && near({1'b0, char_y}, {1'b0, enemy1_y});
          k_d     = '0;
          c_ok_d  = 1'b1;
          e_ok_d  = 1'b1;
          state_d = PROBE;
        end
      end
      PROBE: begin
        // rom_q here belongs to probe k-1 (one-cycle ROM latency)
        if (k_q != 3'd0) begin
          if (k_q <= 3'd4) c_ok_d = c_ok_q & rom_q;
          else             e_ok_d = e_ok_q & rom_q;
        end
        k_d = k_q + 3'd1;
        if (k_q == 3'd7) state_d = DRAIN;
      end
      DRAIN: begin
        e_ok_d  = e_ok_q & rom_q;
        c_map_d = !c_ok_q | exc_c_q;
        e_map_d = !(e_ok_q & rom_q) | exc_e_q;
        c_e1_d  = ovl_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      cd_q    <= '0;
      ex_q    <= '0;
      ey_q    <= '0;
      ed_q    <= '0;
      exc_c_q <= 1'b0;
      exc_e_q <= 1'b0;
      ovl_q   <= 1'b0;
      c_ok_q  <= 1'b1;
      e_ok_q  <= 1'b1;
      addr_q  <= '0;
      c_map_q <= 1'b0;
      e_map_q <= 1'b0;
      c_e1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      cd_q    <= cd_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      ed_q    <= ed_d;
      exc_c_q <= exc_c_d;
      exc_e_q <= exc_e_d;
      ovl_q   <= ovl_d;
      c_ok_q  <= c_ok_d;
      e_ok_q  <= e_ok_d;
      addr_q  <= rom_address;
      c_map_q <= c_map_d;
      e_map_q <= e_map_d;
      c_e1_q  <= c_e1_d;
    end
  end

endmodule

// File: tb/tb_map_probe_sequencer.sv
// Bench for map_probe_sequencer: a timing/arithmetic model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_map_probe_sequencer;

  localparam int NOP = 0, ATK = 1, UP = 2, DN = 3, LF = 4, RT = 5;
  localparam int NO_WALL = 131071;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  char_x = '0, enemy1_x = '0;
  logic [7:0]  char_y = '0, enemy1_y = '0;
  logic [2:0]  direction_char = '0, direction_enemy1 = '0;
  logic [16:0] rom_address;
  logic        rom_q = 1'b0;
  logic        busy, done, c_map_collision, e1_map_collision, c_e1_collision;

  int checks = 0;
  int passes = 0;
  int wall_addr = NO_WALL;

  map_probe_sequencer #(
    .SPRITE_SIZE(16), .MAP_W_PX(256), .MAP_H_PX(176), .LINE_W(320)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .char_x(char_x), .char_y(char_y), .enemy1_x(enemy1_x), .enemy1_y(enemy1_y),
    .direction_char(direction_char), .direction_enemy1(direction_enemy1),
    .rom_address(rom_address), .rom_q(rom_q), .busy(busy), .done(done),
    .c_map_collision(c_map_collision), .e1_map_collision(e1_map_collision),
    .c_e1_collision(c_e1_collision)
  );

  always #5 clock = ~clock;

  // Registered ROM: all walkable except a single wall address
  always @(posedge clock) rom_q <= (int'(rom_address) != wall_addr);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
  endtask

  // Higher-level reference: plain integer arithmetic over the rules
  function automatic void model_check(input int cx, input int cy, input int cd,
                                      input int ex, input int ey, input int ed, input int wall,
                                      output logic [2:0] fl, output logic [7:0][16:0] addrs);
    int xs[2], ys[2], ds[2];
    logic ok[2], exc[2];
    int px, py, ax, ay, a, dx, dy;
    xs[0] = cx; ys[0] = cy; ds[0] = cd;
    xs[1] = ex; ys[1] = ey; ds[1] = ed;
    for (int s = 0; s < 2; s++) begin
      px = (xs[s] + (ds[s] == RT ? 1 : 0) - (ds[s] == LF ? 1 : 0) + 512) % 512;
      py = (ys[s] + (ds[s] == DN ? 1 : 0) - (ds[s] == UP ? 1 : 0) + 256) % 256;
      ok[s] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        ax = (px + 16 * (c % 2)) % 512;
        ay = (py + 16 * (c / 2)) % 256;
        a  = ay * 320 + ax;
        addrs[s * 4 + c] = 17'(a);
        if (a == wall) ok[s] = 1'b0;
      end
      exc[s] = (ys[s] == 0 && ds[s] == UP) || (xs[s] == 0 && ds[s] == LF) ||
               (xs[s] + 16 == 256 && ds[s] == RT) || (ys[s] + 16 == 176 && ds[s] == DN);
    end
    dx = (cx > ex) ? cx - ex : ex - cx;
    dy = (cy > ey) ? cy - ey : ey - cy;
    fl = {!ok[0] || exc[0], !ok[1] || exc[1], (dx < 16) && (dy < 16)};
  endfunction

  int               edge_n = 0, m_t0 = 0;
  logic             m_valid = 1'b0;
  logic [2:0]       m_pend = '0, m_flags = '0;
  logic [7:0][16:0] m_addr = '0;
  logic [16:0]      m_hold = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_flags <= '0;
      m_hold  <= '0;
      edge_n  <= 0;
    end else begin
      if (start && (!m_valid || edge_n - m_t0 >= 10)) begin
        logic [2:0]       f;
        logic [7:0][16:0] a;
        model_check(int'(char_x), int'(char_y), int'(direction_char), int'(enemy1_x),
                    int'(enemy1_y), int'(direction_enemy1), wall_addr, f, a);
        m_t0    <= edge_n;
        m_valid <= 1'b1;
        m_pend  <= f;
        m_addr  <= a;
      end
      if (m_valid && edge_n - m_t0 == 8) m_hold <= m_addr[7];
      if (m_valid && edge_n - m_t0 == 9) m_flags <= m_pend;
      edge_n <= edge_n + 1;
    end
  end

  logic cmp_on = 1'b0;
  int   cyc;
  always @(negedge clock) begin
    if (cmp_on) begin
      cyc = m_valid ? edge_n - m_t0 : 0;
      chk("busy", int'(busy), int'(cyc >= 1 && cyc <= 9));
      chk("done", int'(done), int'(cyc == 10));
      chk("addr", int'(rom_address), (cyc >= 1 && cyc <= 8) ? int'(m_addr[cyc - 1]) : int'(m_hold));
      chk("c_map", int'(c_map_collision), int'(m_flags[2]));
      chk("e1_map", int'(e1_map_collision), int'(m_flags[1]));
      chk("c_e1", int'(c_e1_collision), int'(m_flags[0]));
    end
  end

  logic [7:0][16:0] cap;

  task automatic run(input int cx, input int cy, input int cd, input int ex, input int ey,
                     input int ed, output logic [2:0] fl, output int lat);
    @(negedge clock);
    char_x = 9'(cx); char_y = 8'(cy); direction_char = 3'(cd);
    enemy1_x = 9'(ex); enemy1_y = 8'(ey); direction_enemy1 = 3'(ed);
    start = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      start = 1'b0;
      lat++;
      if (lat <= 8) cap[lat - 1] = rom_address;
      // latched copies must be used, so scramble the live inputs
      char_x = 9'($urandom); char_y = 8'($urandom); direction_char = 3'($urandom_range(0, 5));
      enemy1_x = 9'($urandom); enemy1_y = 8'($urandom); direction_enemy1 = 3'($urandom_range(0, 5));
    end while (!done && lat < 20);
    fl = {c_map_collision, e1_map_collision, c_e1_collision};
  endtask

  logic [2:0] fl;
  int lat, ndone, first_d, second_d;

  initial begin
    repeat (2) @(negedge clock);
    chk("reset_busy", int'(busy), 0);
    chk("reset_addr", int'(rom_address), 0);
    chk("reset_flags", int'({c_map_collision, e1_map_collision, c_e1_collision}), 0);
    reset = 1'b1;
    cmp_on = 1'b1;

    run(100, 80, UP, 40, 40, NOP, fl, lat);
    chk("open_latency", lat, 10);
    chk("open_flags", int'(fl), 0);
    chk("open_addr0", int'(cap[0]), 79 * 320 + 100);
    chk("open_addr1", int'(cap[1]), 79 * 320 + 116);
    chk("open_addr2", int'(cap[2]), 95 * 320 + 100);
    chk("open_addr3", int'(cap[3]), 95 * 320 + 116);

    wall_addr = 95 * 320 + 116;
    run(100, 80, UP, 40, 40, NOP, fl, lat);
    chk("wall_flags", int'(fl), 3'b100);

    wall_addr = NO_WALL;
    run(100, 80, UP, 240, 50, RT, fl, lat);
    chk("edge_right_flags", int'(fl), 3'b010);
    run(100, 80, UP, 240, 50, LF, fl, lat);
    chk("edge_left_flags", int'(fl), 3'b000);
    run(50, 0, UP, 200, 160, DN, fl, lat);
    chk("edge_top_bottom_flags", int'(fl), 3'b110);
    run(0, 90, LF, 300, 20, NOP, fl, lat);
    chk("edge_x0_left_flags", int'(fl), 3'b100);

    run(60, 60, NOP, 75, 70, NOP, fl, lat);
    chk("overlap_75_70", int'(fl), 3'b001);
    run(60, 60, NOP, 76, 70, NOP, fl, lat);
    chk("overlap_76_70", int'(fl), 3'b000);
    run(60, 60, NOP, 60, 76, NOP, fl, lat);
    chk("overlap_60_76", int'(fl), 3'b000);

    wall_addr = 80 * 320 + 100;
    run(100, 80, ATK, 40, 40, NOP, fl, lat);
    chk("attack_unshifted_wall", int'(fl), 3'b100);
    run(300, 150, NOP, 100, 80, NOP, fl, lat);
    chk("enemy_wall", int'(fl), 3'b010);
    wall_addr = NO_WALL;

    // start in cycles 0 and 5 (dropped) and 10
    @(negedge clock);
    char_x = 9'd100; char_y = 8'd80; direction_char = 3'(UP);
    enemy1_x = 9'd40; enemy1_y = 8'd40; direction_enemy1 = 3'(NOP);
    ndone = 0; first_d = -1; second_d = -1;
    for (int j = 0; j <= 25; j++) begin
      if (j > 0) @(negedge clock);
      if (done) begin
        ndone++;
        if (first_d < 0) first_d = j; else second_d = j;
      end
      start = (j == 0 || j == 5 || j == 10);
    end
    start = 1'b0;
    chk("drop_done_count", ndone, 2);
    chk("drop_first_done", first_d, 10);
    chk("drop_second_done", second_d, 20);

    run(100, 80, UP, 240, 50, RT, fl, lat);
    chk("pre_reset_flags", int'(fl), 3'b010);
    for (int j = 0; j <= 4; j++) begin
      @(negedge clock);
      start = (j == 0);
    end
    chk("busy_before_reset", int'(busy), 1);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("reset_mid_busy", int'(busy), 0);
    chk("reset_mid_done", int'(done), 0);
    chk("reset_mid_flags", int'({c_map_collision, e1_map_collision, c_e1_collision}), 0);
    reset = 1'b1;
    ndone = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    chk("no_done_after_reset", ndone, 0);

    run(60, 60, NOP, 75, 70, NOP, fl, lat);
    chk("recover_latency", lat, 10);
    chk("recover_flags", int'(fl), 3'b001);

    repeat (2) @(negedge clock);
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule
